// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack.
// Contents:
//   LIFO_DEFAULT_DEPTH : default number of stack entries.
//   lvl_width()        : bits needed to hold an occupancy of 0..depth.
//   addr_width()       : bits needed to address entries 0..depth-1.
package lifo_pkg;

    // Default stack depth used when the instantiating block does not override it.
    localparam int LIFO_DEFAULT_DEPTH = 8;

    // Occupancy runs 0..depth inclusive, so it needs one extra code point.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Addresses run 0..depth-1.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// DEPTH x DATA_W register array for the LIFO stack.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// The array is deliberately not reset; the owner tracks which entries are live.
module lifo_stack_mem
    import lifo_pkg::*;
#(
    parameter int  DEPTH  = LIFO_DEFAULT_DEPTH,
    parameter int  DATA_W = 8,
    localparam int AW     = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack_hs.sv
// Parameterised LIFO stack with valid/ready push and pop interfaces.
// Ports:
//   clk, reset (sync, active-low), clear (sync flush, active-high)
//   push_valid/push_ready/push_data : producer side
//   pop_valid/pop_ready/pop_data    : consumer side, pop_data shows the top entry
//   level, empty, full, almost_full : occupancy status
//   max_level                       : high-water mark since reset/clear
//   overflow, underflow             : sticky protocol-misuse flags
module lifo_stack_hs
    import lifo_pkg::*;
#(
    parameter int  DEPTH    = LIFO_DEFAULT_DEPTH,
    parameter int  DATA_W   = 8,
    parameter int  AF_LEVEL = DEPTH - 1,
    localparam int LVL_W    = lvl_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [LVL_W-1:0]  max_level,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = addr_width(DEPTH);

    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  max_level_q, max_level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              push_fire_s;
    logic              pop_fire_s;
    logic              we_s;
    logic [AW-1:0]     waddr_s;
    logic [AW-1:0]     raddr_s;
    logic [DATA_W-1:0] rdata_s;

    // Status derived purely from the registered occupancy.
    assign empty       = (level_q == {LVL_W{1'b0}});
    assign full        = (level_q == LVL_W'(DEPTH));
    assign almost_full = (level_q >= LVL_W'(AF_LEVEL));
    assign push_ready  = ~full;
    assign pop_valid   = ~empty;

    assign push_fire_s = push_valid & push_ready;
    assign pop_fire_s  = pop_valid & pop_ready;

    // Top entry lives at level-1; the address is meaningless when empty, so the output is masked.
    assign raddr_s  = AW'(level_q - LVL_W'(1));
    assign pop_data = empty ? {DATA_W{1'b0}} : rdata_s;

    // Next-state for occupancy, write port, high-water mark and sticky flags.
    always_comb begin
        level_d = level_q;
        we_s    = 1'b0;
        waddr_s = AW'(level_q);
        case ({push_fire_s, pop_fire_s})
            2'b10: begin
                level_d = level_q + LVL_W'(1);
                we_s    = 1'b1;
                waddr_s = AW'(level_q);
            end
            2'b01: begin
                level_d = level_q - LVL_W'(1);
            end
            2'b11: begin
                // Consumer takes the old top while the new word overwrites that slot.
                level_d = level_q;
                we_s    = 1'b1;
                waddr_s = raddr_s;
            end
            default: begin
                level_d = level_q;
            end
        endcase

        // A flush or reset this cycle discards the push.
        if (!reset || clear) begin
            we_s = 1'b0;
        end else begin
            we_s = we_s;
        end

        if (level_d > max_level_q) begin
            max_level_d = level_d;
        end else begin
            max_level_d = max_level_q;
        end

        overflow_d  = overflow_q  | (push_valid & ~push_ready);
        underflow_d = underflow_q | (pop_ready  & ~pop_valid);
    end

    // Control state: reset has priority over clear, clear over normal traffic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q     <= {LVL_W{1'b0}};
            max_level_q <= {LVL_W{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            level_q     <= {LVL_W{1'b0}};
            max_level_q <= {LVL_W{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            max_level_q <= max_level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign level     = level_q;
    assign max_level = max_level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    lifo_stack_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (push_data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

endmodule

// File: tb/tb_lifo_stack_hs.sv
// Directed bench for lifo_stack_hs (DEPTH=4, DATA_W=8, AF_LEVEL=3).
// Expected pop words go into a scoreboard queue as stimulus is issued; a
// negedge monitor compares them whenever a pop handshake completes.
module tb_lifo_stack_hs;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int LVL_W  = 3;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic [LVL_W-1:0]  level;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [LVL_W-1:0]  max_level;
    logic              overflow;
    logic              underflow;

    int                n_vec  = 0;
    int                n_miss = 0;
    logic [DATA_W-1:0] sb_q [$];

    lifo_stack_hs #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_data   (push_data),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_data    (pop_data),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .max_level   (max_level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every completed pop must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && !clear && pop_valid && pop_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL pop_unexpected: got 0x%02h, required no pop", pop_data);
            end else begin
                logic [DATA_W-1:0] exp_w;
                exp_w = sb_q.pop_front();
                if (pop_data !== exp_w) begin
                    n_miss++;
                    $display("FAIL pop_data: got 0x%02h, required 0x%02h", pop_data, exp_w);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_state(input string tag, input int lvl, input int mx,
                             input int ovf, input int unf, input int top);
        chk({tag, ".level"},       int'(level),       lvl);
        chk({tag, ".max_level"},   int'(max_level),   mx);
        chk({tag, ".overflow"},    int'(overflow),    ovf);
        chk({tag, ".underflow"},   int'(underflow),   unf);
        chk({tag, ".pop_data"},    int'(pop_data),    top);
        chk({tag, ".empty"},       int'(empty),       (lvl == 0) ? 1 : 0);
        chk({tag, ".full"},        int'(full),        (lvl == DEPTH) ? 1 : 0);
        chk({tag, ".almost_full"}, int'(almost_full), (lvl >= 3) ? 1 : 0);
        chk({tag, ".push_ready"},  int'(push_ready),  (lvl == DEPTH) ? 0 : 1);
        chk({tag, ".pop_valid"},   int'(pop_valid),   (lvl == 0) ? 0 : 1);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        pop_ready  = 1'b0;
        cyc();
        push_valid = 1'b0;
    endtask

    task automatic pop(input logic [DATA_W-1:0] e);
        sb_q.push_back(e);
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        cyc();
        pop_ready  = 1'b0;
    endtask

    // From empty: underflow via push+pop on empty, fill, overflow, pop one -> level 3, top 0x99.
    task automatic build_state();
        push_valid = 1'b1;
        push_data  = 8'h77;
        pop_ready  = 1'b1;
        cyc();
        pop_ready  = 1'b0;
        push(8'h88);
        push(8'h99);
        push(8'hAA);
        push(8'hBB);
        pop(8'hAA);
    endtask

    initial begin
        reset      = 1'b0;
        clear      = 1'b0;
        push_valid = 1'b0;
        push_data  = 8'h00;
        pop_ready  = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk_state("reset", 0, 0, 0, 0, 8'h00);

        // Fill then drain in LIFO order.
        push(8'h11);
        push(8'h22);
        chk_state("t2_l2", 2, 2, 0, 0, 8'h22);
        push(8'h33);
        chk_state("t2_l3", 3, 3, 0, 0, 8'h33);
        push(8'h44);
        chk_state("t2_full", 4, 4, 0, 0, 8'h44);
        pop(8'h44);
        pop(8'h33);
        pop(8'h22);
        pop(8'h11);
        chk_state("t2_empty", 0, 4, 0, 0, 8'h00);

        // Same-cycle push and pop replaces the top.
        push(8'h11);
        push(8'h22);
        chk_state("t3_l2", 2, 4, 0, 0, 8'h22);
        sb_q.push_back(8'h22);
        push_valid = 1'b1;
        push_data  = 8'hAA;
        pop_ready  = 1'b1;
        cyc();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk_state("t3_swap", 2, 4, 0, 0, 8'hAA);
        pop(8'hAA);
        pop(8'h11);
        chk_state("t3_empty", 0, 4, 0, 0, 8'h00);

        // Full stack: only the pop fires, push stalls and overflow sets.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        sb_q.push_back(8'h44);
        push_valid = 1'b1;
        push_data  = 8'h55;
        pop_ready  = 1'b1;
        cyc();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk_state("t4_full_pp", 3, 4, 1, 0, 8'h33);
        pop(8'h33);
        pop(8'h22);
        pop(8'h11);
        chk_state("t4_empty", 0, 4, 1, 0, 8'h00);

        // Empty stack: only the push fires, underflow sets.
        push_valid = 1'b1;
        push_data  = 8'h77;
        pop_ready  = 1'b1;
        cyc();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk_state("t5_empty_pp", 1, 4, 1, 1, 8'h77);

        // Plain clear from a non-empty state.
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk_state("t6_clr0", 0, 0, 0, 0, 8'h00);

        // Clear with push and pop requested: everything returns to reset state.
        build_state();
        chk_state("t6_built", 3, 4, 1, 1, 8'h99);
        clear      = 1'b1;
        push_valid = 1'b1;
        push_data  = 8'hEE;
        pop_ready  = 1'b1;
        cyc();
        clear      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk_state("t6_clear", 0, 0, 0, 0, 8'h00);
        push(8'h5A);
        chk_state("t6_after", 1, 1, 0, 0, 8'h5A);
        pop(8'h5A);

        // Same again using reset mid-stream.
        build_state();
        chk_state("t6_built2", 3, 4, 1, 1, 8'h99);
        reset      = 1'b0;
        push_valid = 1'b1;
        push_data  = 8'hEE;
        pop_ready  = 1'b1;
        cyc();
        reset      = 1'b1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk_state("t6_reset", 0, 0, 0, 0, 8'h00);

        cyc();
        cyc();
        chk("sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lifo_stack_hs.md
Name: lifo_stack_hs

Overview:
- Second-generation parameterised LIFO (stack) buffer with valid/ready push and pop interfaces.
- Show-ahead top-of-stack output, same-cycle push+pop (top replace), occupancy count, almost-full threshold, flush, sticky protocol-error flags and a high-water mark.
- Used as a generic stack primitive (return-address / undo / backtrack storage) between a producer and a consumer in the same clock domain.

Parameters:
DEPTH     8          number of entries; legal range >= 2
DATA_W    8          entry width in bits; legal range >= 1
AF_LEVEL  DEPTH-1    almost_full asserts when level >= AF_LEVEL; legal range 1..DEPTH
LVL_W     $clog2(DEPTH+1)  derived (localparam), width of level and max_level

Ports:
clk         in   1       rising-edge clock
reset       in   1       synchronous, active-low reset
clear       in   1       synchronous flush, active-high
push_valid  in   1       producer presents push_data
push_ready  out  1       stack can accept a push this cycle
push_data   in   DATA_W  data to push
pop_valid   out  1       pop_data holds a valid top entry
pop_ready   in   1       consumer takes the top entry
pop_data    out  DATA_W  current top of stack (show-ahead)
level       out  LVL_W   current occupancy, 0..DEPTH
empty       out  1       level == 0
full        out  1       level == DEPTH
almost_full out  1       level >= AF_LEVEL
max_level   out  LVL_W   highest level reached since reset/clear
overflow    out  1       sticky: push_valid seen while push_ready low
underflow   out  1       sticky: pop_ready seen while pop_valid low

Behaviour:
- Reset (reset==0 at a clk edge): level=0, max_level=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_full=0, push_ready=1, pop_valid=0, pop_data=0. Storage array is not reset.
- Priority: reset > clear > push/pop. clear has the same effect as reset on all state; push/pop in the same cycle are ignored.
- push_ready = !full; pop_valid = !empty. Neither depends combinationally on the other side's valid/ready.
- push_fire = push_valid & push_ready; pop_fire = pop_valid & pop_ready.
- pop_data = mem[level-1] when !empty, else all-zero. Combinational from registered state.
- push_fire only: mem[level] <= push_data, level+1. New data appears on pop_data the next cycle (1-cycle latency).
- pop_fire only: level-1. Next-lower entry appears on pop_data the next cycle.
- push_fire and pop_fire together (only possible when 0 < level < DEPTH): consumer takes the old top this cycle; mem[level-1] <= push_data; level unchanged.
- full with push_valid and pop_ready: only the pop fires; push stalls and overflow sets.
- empty with push_valid and pop_ready: only the push fires; underflow sets.
- overflow/underflow are sticky until reset or clear. They flag producer/consumer protocol misuse only; state is never corrupted.
- max_level <= max(max_level, next level) every cycle.
- Status outputs (empty, full, almost_full) derive from level. No wrap-around: level saturates by construction via the ready/valid gating.

Decomposition:
- Shared package lifo_pkg: clog2-based width helper and a documented default-depth constant.
- One sub-module, lifo_stack_mem: DEPTH x DATA_W register array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- Top level holds the level counter, handshake logic, flags and max_level.

Test Plan:
1. Reset with DEPTH=4, DATA_W=8 -> level=0, empty=1, push_ready=1, pop_valid=0, pop_data=0x00, flags=0.
2. Push 0x11,0x22,0x33,0x44 back-to-back -> level=4, full=1, almost_full set at level 3, push_ready=0. Then pop 4 times -> data 0x44,0x33,0x22,0x11, empty=1.
3. Level=2 (top 0x22), push 0xAA with pop in the same cycle -> pop_data 0x22 taken; next cycle pop_data=0xAA, level=2.
4. Full stack (top 0x44), push_valid+pop_ready with data 0x55 -> pop of 0x44 only; level=3, overflow=1, top=0x33.
5. Empty stack, pop_ready=1 with push_valid 0x77 -> level=1, pop_data=0x77 next cycle, underflow=1.
6. Level=3, max_level=4, flags set, assert clear with push_valid=1 -> level=0, max_level=0, flags=0, push ignored. Repeat using reset mid-stream -> identical result.
